// File: rtl/div_hilo_ctrl.sv
// rtl/div_hilo_ctrl.sv - issue-side divide controller with HI/LO ownership
//
// Takes DIV/DIVU requests from execute, feeds operand magnitudes to an
// unsigned multicycle divider, sign-corrects its quotient and remainder,
// and commits them to HI/LO. Also services MTHI/MTLO and drives the stall.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   op_valid, op_signed          divide request, 1 = DIV / 0 = DIVU
//   rs_val, rt_val               dividend, divisor
//   flush                        abort outstanding divide, no commit
//   hi_we, lo_we, wdata          MTHI/MTLO writes (IDLE only)
//   stall                        freeze upstream pipeline
//   hi, lo                       architectural HI/LO
//   done                         one-cycle pulse on a divide commit
//   div_start                    divider start (registered)
//   div_dividend, div_divisor    operand magnitudes to the divider (registered)
//   div_q, div_r, div_busy       divider results and busy flag
module div_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state;
    logic   neg_q;
    logic   neg_r;
    logic   seen_busy;

    logic             accept;
    logic             rt_zero;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [WIDTH-1:0] q_fixed;
    logic [WIDTH-1:0] r_fixed;

    always_comb begin
        accept  = op_valid & ~flush;
        rt_zero = (rt_val == '0);
        rs_neg  = op_signed & rs_val[WIDTH-1];
        rt_neg  = op_signed & rt_val[WIDTH-1];
        rs_mag  = rs_neg ? -rs_val : rs_val;
        rt_mag  = rt_neg ? -rt_val : rt_val;
        q_fixed = neg_q ? -div_q : div_q;
        r_fixed = neg_r ? -div_r : div_r;
        // Divide-by-zero completes in IDLE, so it never stalls.
        stall   = (state != S_IDLE) | (accept & ~rt_zero);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            hi           <= '0;
            lo           <= '0;
            done         <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            seen_busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    div_start <= 1'b0;
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        if (rt_zero) begin
                            hi   <= rs_val;
                            lo   <= '1;
                            done <= 1'b1;
                        end else begin
                            neg_q        <= rs_neg ^ rt_neg;
                            neg_r        <= rs_neg;
                            div_dividend <= rs_mag;
                            div_divisor  <= rt_mag;
                            if (div_busy) begin
                                // Divider still chewing on a flushed op:
                                // wait for it to finish before starting.
                                state     <= S_DRAIN;
                                seen_busy <= 1'b1;
                            end else begin
                                state     <= S_LAUNCH;
                                div_start <= 1'b1;
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    // Start was high for the whole cycle so the divider's
                    // falling-edge sample has caught it.
                    div_start <= 1'b0;
                    seen_busy <= 1'b0;
                    state     <= flush ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (seen_busy && !div_busy) begin
                        lo    <= q_fixed;
                        hi    <= r_fixed;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (div_busy) begin
                        seen_busy <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (seen_busy && !div_busy) begin
                        state     <= S_LAUNCH;
                        div_start <= 1'b1;
                    end else if (div_busy) begin
                        seen_busy <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb/tb_div_hilo_ctrl.sv - scoreboard bench for div_hilo_ctrl with a behavioural divider
module tb_div_hilo_ctrl;

    logic        clock;
    logic        reset;
    logic        op_valid;
    logic        op_signed;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_busy;

    div_hilo_ctrl #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_signed(op_signed),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .stall(stall), .hi(hi), .lo(lo), .done(done),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_q(div_q), .div_r(div_r), .div_busy(div_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] l;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   start_count = 0;
    int   lat = 33;

    // Behavioural divider: samples start on falling edges, busy for lat falling
    // edges counting the start edge, reset by the same net (seen at posedge).
    logic rst_seen = 1'b0;
    int   m_cnt = 0;
    always @(posedge clock) rst_seen <= reset;
    always @(negedge clock) begin
        if (rst_seen) begin
            div_busy = 1'b0;
            m_cnt    = 0;
        end else if (div_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt <= 0) div_busy = 1'b0;
        end else if (div_start) begin
            div_busy    = 1'b1;
            m_cnt       = lat - 1;
            start_count = start_count + 1;
            div_q       = (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
            div_r       = (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
        end
    end

    always @(posedge clock) begin
        #2;
        if (done) done_count = done_count + 1;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    function automatic res_t ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        longint sa, sb;
        if (b == 0) begin
            r.h = a;
            r.l = 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            r.l = 32'(sa / sb);
            r.h = 32'(sa % sb);
        end else begin
            r.l = a / b;
            r.h = a % b;
        end
        return r;
    endfunction

    // Issue one op, wait for its done, compare against the scoreboard.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input res_t e, input int exp_stall);
        int   n;
        int   dc0;
        logic seen;
        res_t got;
        exp_q.push_back(e);
        dc0 = done_count;
        tick();
        op_valid = 1'b1; op_signed = sgn; rs_val = a; rt_val = b;
        #1;
        n = stall ? 1 : 0;
        tick();
        op_valid = 1'b0;
        #1;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin seen = 1'b1; break; end
            if (stall) n++;
            tick();
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done never seen within 300 cycles", name);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall_at_done: stall=%b required 0", name, stall);
        end
        checks++;
        if (n !== exp_stall) begin
            errors++;
            $display("FAIL %s_stall_cycles: got %0d required %0d", name, n, exp_stall);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: expected queue empty", name);
        end else begin
            got = exp_q.pop_front();
            if (hi !== got.h || lo !== got.l) begin
                errors++;
                $display("FAIL %s_result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, got.h, got.l);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || done_count - dc0 !== 1) begin
            errors++;
            $display("FAIL %s_done_once: done=%b pulses=%0d required 0/1", name, done, done_count - dc0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 0; op_signed = 0; rs_val = 0; rt_val = 0;
        flush = 0; hi_we = 0; lo_we = 0; wdata = 0;
        div_q = 0; div_r = 0; div_busy = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++;
        if (hi !== 0 || lo !== 0 || done !== 0 || stall !== 0) begin
            errors++;
            $display("FAIL reset_hilo: hi=%h lo=%h done=%b stall=%b required all 0", hi, lo, done, stall);
        end
        checks++;
        if (div_start !== 0 || div_dividend !== 0 || div_divisor !== 0) begin
            errors++;
            $display("FAIL reset_div_if: start=%b dd=%h dv=%h required all 0", div_start, div_dividend, div_divisor);
        end
    endtask

    task automatic test_arith();
        lat = 33;
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, '{h: 32'd2, l: 32'd14}, 34);
        run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, '{h: 32'hFFFF_FFFE, l: 32'hFFFF_FFF2}, 34);
        run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, '{h: 32'd2, l: 32'hFFFF_FFF2}, 34);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '{h: 32'd0, l: 32'h8000_0000}, 34);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, '{h: 32'd0, l: 32'hFFFF_FFFF}, 34);
    endtask

    task automatic test_random();
        logic        s;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            lat = int'($urandom_range(3, 40));
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 28);
            if (b == 0) b = 32'd3;
            run_div("rand", s, a, b, ref_div(s, a, b), lat + 1);
        end
        lat = 33;
    endtask

    task automatic test_div_by_zero();
        int s0;
        s0 = start_count;
        run_div("div0", 1'b0, 32'h1234, 32'd0, '{h: 32'h1234, l: 32'hFFFF_FFFF}, 0);
        run_div("div0_signed", 1'b1, 32'hFFFF_FF00, 32'd0, '{h: 32'hFFFF_FF00, l: 32'hFFFF_FFFF}, 0);
        tick();
        checks++;
        if (start_count !== s0) begin
            errors++;
            $display("FAIL div0_no_start: starts=%0d required %0d", start_count - s0, 0);
        end
    endtask

    task automatic test_flush_drain();
        int   dc0, s0;
        logic seen;
        res_t got;
        lat = 33; dc0 = done_count; s0 = start_count;
        tick();
        op_valid = 1; op_signed = 0; rs_val = 32'd1000; rt_val = 32'd3;
        tick();
        op_valid = 0;
        for (int k = 0; k < 11; k++) tick();
        flush = 1;
        tick();
        flush = 0;
        exp_q.push_back('{h: 32'd1, l: 32'd4});
        op_valid = 1; op_signed = 0; rs_val = 32'd9; rt_val = 32'd2;
        tick();
        op_valid = 0;
        #1;
        checks++;
        if (stall !== 1'b1 || div_start !== 1'b0 || div_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_drain_entry: stall=%b start=%b busy=%b required 1/0/1", stall, div_start, div_busy);
        end
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen || done_count - dc0 !== 1) begin
            errors++;
            $display("FAIL flush_done: seen=%b pulses=%0d required 1/1", seen, done_count - dc0);
        end
        checks++;
        got = exp_q.pop_front();
        if (hi !== got.h || lo !== got.l) begin
            errors++;
            $display("FAIL flush_result: hi=%h lo=%h required hi=%h lo=%h", hi, lo, got.h, got.l);
        end
        checks++;
        if (start_count - s0 !== 2) begin
            errors++;
            $display("FAIL flush_starts: got %0d required 2", start_count - s0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int   dc0;
        logic seen;
        res_t got;
        lat = 8; dc0 = done_count;
        exp_q.push_back(ref_div(1'b0, 32'd77, 32'd5));
        exp_q.push_back(ref_div(1'b1, 32'hFFFF_FFC0, 32'd6));
        tick();
        op_valid = 1; op_signed = 0; rs_val = 32'd77; rt_val = 32'd5;
        tick();
        op_valid = 0;
        for (int j = 0; j < 2; j++) begin
            seen = 0;
            for (int k = 0; k < 100; k++) begin
                if (done) begin seen = 1; break; end
                tick();
            end
            checks++;
            got = exp_q.pop_front();
            if (!seen || hi !== got.h || lo !== got.l) begin
                errors++;
                $display("FAIL b2b_result%0d: seen=%b hi=%h lo=%h required hi=%h lo=%h", j, seen, hi, lo, got.h, got.l);
            end
            if (j == 0) begin
                op_valid = 1; op_signed = 1; rs_val = 32'hFFFF_FFC0; rt_val = 32'd6;
            end
            tick();
            op_valid = 0;
        end
        checks++;
        if (done_count - dc0 !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d required 2", done_count - dc0);
        end
        lat = 33;
    endtask

    task automatic test_mt_and_reset();
        int dc0;
        tick();
        hi_we = 1; lo_we = 1; wdata = 32'hAAAA;
        tick();
        lo_we = 1; hi_we = 0; wdata = 32'h5555;
        tick();
        lo_we = 0;
        checks++;
        if (hi !== 32'hAAAA || lo !== 32'h5555) begin
            errors++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h required hi=0000aaaa lo=00005555", hi, lo);
        end
        dc0 = done_count;
        op_valid = 1; op_signed = 0; rs_val = 32'd50; rt_val = 32'd5;
        tick();
        op_valid = 0;
        for (int k = 0; k < 6; k++) tick();
        hi_we = 1; wdata = 32'h1111;
        tick();
        hi_we = 0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (hi !== 32'hAAAA || stall !== 1'b1) begin
            errors++;
            $display("FAIL mthi_in_wait: hi=%h stall=%b required hi=0000aaaa stall=1", hi, stall);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (hi !== 0 || lo !== 0 || stall !== 0 || done !== 0 || div_start !== 0) begin
            errors++;
            $display("FAIL reset_mid_wait: hi=%h lo=%h stall=%b done=%b start=%b required all 0",
                     hi, lo, stall, done, div_start);
        end
        for (int k = 0; k < 60; k++) tick();
        checks++;
        if (done_count !== dc0 || hi !== 0 || lo !== 0) begin
            errors++;
            $display("FAIL reset_no_commit: pulses=%0d hi=%h lo=%h required 0/0/0", done_count - dc0, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_random();
        test_div_by_zero();
        test_flush_drain();
        test_back_to_back();
        test_mt_and_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
